// File: rtl/enigma_rotor_stepper_if.sv
// ---------------------------------------------------------------------------
// enigma_rotor_stepper_if
//   Character stream interface between a producer, the rotor stepper and the
//   caesar lookup.
//   Input side : in_valid / in_ready / char_in      (producer -> stepper)
//   Output side: out_valid / out_ready / out_is_letter / out_char / sel
//                                                   (stepper -> lookup)
//   master modport: the environment that feeds characters and drains results.
//   slave modport : the stepper itself.
// ---------------------------------------------------------------------------
interface enigma_rotor_stepper_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  char_in;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_letter;
  logic [7:0]  out_char;
  logic [31:0] sel;

  modport master (
    output in_valid, char_in, out_ready,
    input  in_ready, out_valid, out_is_letter, out_char, sel
  );

  modport slave (
    input  in_valid, char_in, out_ready,
    output in_ready, out_valid, out_is_letter, out_char, sel
  );
endinterface

// File: rtl/enigma_rotor_stepper.sv
// ---------------------------------------------------------------------------
// enigma_rotor_stepper
//   Accepts one ASCII character at a time, steps a three-rotor position
//   register with Enigma odometer rules (including the middle-rotor double
//   step) and emits the alphabet index of the character offset by the sum of
//   the rotor positions, modulo 26, as the select index of the caesar lookup.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     key_load            load start positions (only honoured in IDLE)
//     key_l/key_m/key_r   start positions; values above 25 load as 0
//     bus (slave)         in_valid/in_ready/char_in and
//                         out_valid/out_ready/out_is_letter/out_char/sel
//     pos_l/pos_m/pos_r   registered rotor positions
//
//   Flow: IDLE (accept) -> STEP (rotate + compute) -> OUT (hold until taken).
// ---------------------------------------------------------------------------
module enigma_rotor_stepper #(
  parameter int ALPHA   = 26,
  parameter int NOTCH_R = 21,
  parameter int NOTCH_M = 4,
  parameter int NOTCH_L = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_load,
  input  logic [4:0]                   key_l,
  input  logic [4:0]                   key_m,
  input  logic [4:0]                   key_r,
  enigma_rotor_stepper_if.slave        bus,
  output logic [4:0]                   pos_l,
  output logic [4:0]                   pos_m,
  output logic [4:0]                   pos_r
);

  // The left notch has no rotor above it to drive; it is kept as a parameter
  // so rotor wirings stay described in one place, and range-checked here.
  if ((NOTCH_R >= ALPHA) || (NOTCH_M >= ALPHA) || (NOTCH_L >= ALPHA)) begin : g_bad_notch
    $error("enigma_rotor_stepper: notch position outside the alphabet");
  end

  localparam logic [4:0] LAST_C    = 5'(ALPHA - 1);
  localparam logic [4:0] NOTCH_R_C = 5'(NOTCH_R);
  localparam logic [4:0] NOTCH_M_C = 5'(NOTCH_M);
  localparam logic [6:0] ALPHA_C   = 7'(ALPHA);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // One-position advance with wrap from the last letter back to 0.
  function automatic logic [4:0] inc_pos(input logic [4:0] p);
    return (p == LAST_C) ? 5'd0 : (p + 5'd1);
  endfunction

  // Out-of-range start keys are forced to position 0.
  function automatic logic [4:0] clamp_key(input logic [4:0] k);
    return (k > LAST_C) ? 5'd0 : k;
  endfunction

  // Reduce a sum of at most 100 into 0..25 by up to three subtractions.
  function automatic logic [4:0] mod_alpha(input logic [6:0] s);
    logic [6:0] t;
    t = s;
    if (t >= ALPHA_C) t = t - ALPHA_C;
    if (t >= ALPHA_C) t = t - ALPHA_C;
    if (t >= ALPHA_C) t = t - ALPHA_C;
    return t[4:0];
  endfunction

  state_t      state_r, next_state_s;
  logic [4:0]  pos_l_r, pos_m_r, pos_r_r;
  logic [7:0]  char_r;
  logic        out_valid_r;
  logic        out_is_letter_r;
  logic [4:0]  sel_r;

  logic        in_ready_s;
  logic        load_s;
  logic        accept_s;
  logic        done_s;
  logic        is_upper_s, is_lower_s, is_letter_s;
  logic [4:0]  idx_s;
  logic [4:0]  nxt_l_s, nxt_m_s, nxt_r_s;
  logic [6:0]  sum_s;
  logic [4:0]  sel_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and handshake decode; a key load in IDLE blocks acceptance.
  always_comb begin
    next_state_s = state_r;
    in_ready_s   = 1'b0;
    load_s       = 1'b0;
    accept_s     = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = ~key_load;
        if (key_load) begin
          load_s = 1'b1;
        end else if (bus.in_valid) begin
          accept_s     = 1'b1;
          next_state_s = ST_STEP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_STEP: begin
        next_state_s = ST_OUT;
      end
      ST_OUT: begin
        if (out_valid_r && bus.out_ready) begin
          done_s       = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_OUT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Letter classification, rotor stepping on pre-step positions, and the
  // select index computed from the post-step positions.
  always_comb begin
    is_upper_s  = (char_r >= 8'd65) && (char_r <= 8'd90);
    is_lower_s  = (char_r >= 8'd97) && (char_r <= 8'd122);
    is_letter_s = is_upper_s | is_lower_s;
    idx_s       = 5'd0;
    if (is_upper_s) begin
      idx_s = 5'(char_r - 8'd65);
    end else if (is_lower_s) begin
      idx_s = 5'(char_r - 8'd97);
    end else begin
      idx_s = 5'd0;
    end

    nxt_r_s = inc_pos(pos_r_r);
    nxt_m_s = pos_m_r;
    nxt_l_s = pos_l_r;
    // A middle rotor sitting on its notch steps itself and the left rotor;
    // this also covers the case where the right notch would step it anyway.
    if (pos_m_r == NOTCH_M_C) begin
      nxt_m_s = inc_pos(pos_m_r);
      nxt_l_s = inc_pos(pos_l_r);
    end else if (pos_r_r == NOTCH_R_C) begin
      nxt_m_s = inc_pos(pos_m_r);
    end else begin
      nxt_m_s = pos_m_r;
    end

    sum_s = {2'd0, idx_s} + {2'd0, nxt_l_s} + {2'd0, nxt_m_s} + {2'd0, nxt_r_s};
    sel_s = mod_alpha(sum_s);
  end

  // Rotor positions, captured character and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_l_r         <= 5'd0;
      pos_m_r         <= 5'd0;
      pos_r_r         <= 5'd0;
      char_r          <= 8'd0;
      out_valid_r     <= 1'b0;
      out_is_letter_r <= 1'b0;
      sel_r           <= 5'd0;
    end else begin
      if (load_s) begin
        pos_l_r <= clamp_key(key_l);
        pos_m_r <= clamp_key(key_m);
        pos_r_r <= clamp_key(key_r);
      end
      if (accept_s) begin
        char_r <= bus.char_in;
      end
      if (state_r == ST_STEP) begin
        if (is_letter_s) begin
          pos_l_r <= nxt_l_s;
          pos_m_r <= nxt_m_s;
          pos_r_r <= nxt_r_s;
          sel_r   <= sel_s;
        end else begin
          sel_r   <= 5'd0;
        end
        out_is_letter_r <= is_letter_s;
        out_valid_r     <= 1'b1;
      end
      if (done_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_is_letter = out_is_letter_r;
  assign bus.out_char      = char_r;
  assign bus.sel           = {27'd0, sel_r};
  assign pos_l             = pos_l_r;
  assign pos_m             = pos_m_r;
  assign pos_r             = pos_r_r;

endmodule

// File: doc/enigma_rotor_stepper.md
Name: enigma_rotor_stepper

Overview:
- Upstream stage of the caesar substitution lookup: accepts one ASCII character per transaction and steps a three-rotor position register using Enigma odometer rules with the double-step anomaly.
- Converts each letter to an alphabet index, adds the combined rotor offset modulo 26, and presents the result as the 32-bit select index consumed by the caesar lookup.
- Valid/ready on both sides; one character in flight at a time.

Parameters:
- ALPHA, 26, alphabet size; all positions and indices are 0..ALPHA-1.
- NOTCH_R, 21, right-rotor turnover position ('V').
- NOTCH_M, 4, middle-rotor turnover position ('E').
- NOTCH_L, 16, left-rotor notch ('Q'); stored only, since no rotor sits above left.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_load  in  1  load start positions; honoured only in IDLE.
- key_l  in  5  left start position.
- key_m  in  5  middle start position.
- key_r  in  5  right start position.
- in_valid  in  1  char_in valid.
- in_ready  out  1  stepper can accept a character.
- char_in  in  8  ASCII character.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_is_letter  out  1  1 = char was A–Z/a–z; 0 = pass-through.
- out_char  out  8  registered copy of the accepted char_in.
- sel  out  32  substitution index, zero-extended, 0..25; 0 when out_is_letter=0.
- pos_l  out  5  current left-rotor position.
- pos_m  out  5  current middle-rotor position.
- pos_r  out  5  current right-rotor position.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pos_l/m/r=0.
  - out_valid=0, out_is_letter=0, out_char=0, sel=0.
  - in_ready=1 after release.
  - Reset mid-operation aborts the in-flight character; no output is produced for it.
- FSM states: IDLE, STEP, OUT.
  - IDLE: in_ready = ~key_load.
    - key_load=1 → load positions; any key value >25 loads 0; stay IDLE; no char accepted that cycle (load wins).
    - in_valid & in_ready → latch char_in, go to STEP.
  - STEP (one cycle): in_ready=0.
    - If latched char is a letter: classify idx ('A'–'Z' → c-65, 'a'–'z' → c-97) and apply stepping, evaluated on pre-step positions:
      - R always advances.
      - If R==NOTCH_R, M advances.
      - If M==NOTCH_M, both M and L advance (double step).
      - Every advance wraps 25→0.
    - Non-letter: no stepping.
    - Go to OUT.
  - OUT: out_valid=1; sel, out_char, out_is_letter stable until handshake.
    - Letter: sel = (idx + pos_l + pos_m + pos_r) mod 26, using post-step positions. Compute in 7 bits (max 100) and reduce by conditional subtraction of 26 up to three times.
    - out_valid & out_ready → out_valid=0 next cycle, go to IDLE.
- Latency:
  - Accept in cycle N; out_valid high in cycle N+2.
  - With out_ready held high, sustained throughput is 1 char per 3 cycles.
- key_load in STEP or OUT is ignored.
- Positions change only in STEP; pos_* outputs are always the registered positions.

Test Plan:
- Reset, then send 'A' with out_ready=1 → out_valid at accept+2; pos=(0,0,1); sel=1; out_is_letter=1; out_char=0x41.
- key_load (0,3,21), send 'A','A':
  - 1st → pos=(0,4,22), sel=0.
  - 2nd (double step) → pos=(1,5,23), sel=3.
- key_load (0,0,25), send 'b' → R wraps to 0, M unchanged; pos=(0,0,0); sel=1.
- Send ' ' (0x20) → out_is_letter=0, sel=0, out_char=0x20, positions unchanged.
- Hold out_ready=0 for 5 cycles while in OUT:
  - out_valid and sel stable; in_ready=0; a new in_valid is not accepted.
  - Release → next char accepted in the following IDLE cycle.
- Assert key_load with in_valid in IDLE → load only, in_ready=0; char accepted next cycle. Pull rst_n low during STEP → all outputs/positions 0 immediately, no out_valid.
